// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: shared FSM state, Booth digit type and iteration count for alu_mul_seq
package alu_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;
  function automatic int iter_count(input int w);
    return w / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder, {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}
module booth_r4_enc
  import alu_mul_pkg::*;
(
  input  logic [2:0]   bits,
  output booth_digit_t digit
);
  always_comb begin
    digit.neg = bits[2] & ~(bits[1] & bits[0]);
    digit.one = bits[1] ^ bits[0];
    digit.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
  end
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative radix-4 Booth multiplier, signed/unsigned, fixed WIDTH/2+1 cycle latency.
// Define ALU_MUL_SEQ_OVF_EN to add the ovf output (product does not fit in WIDTH bits).
module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
`ifdef ALU_MUL_SEQ_OVF_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] P
);
  localparam int ITER = iter_count(WIDTH);
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(ITER + 1);
  state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, mcand, mag;
  logic [WIDTH+2:0] mq;
  logic [CW-1:0] cnt;
  logic sgn, accept, last;
  booth_digit_t dig;
  booth_r4_enc u_enc (.bits(mq[2:0]), .digit(dig));
  always_comb begin
    accept = start && state != RUN;
    last = state == RUN && cnt == CW'(ITER - 1);
    state_nxt = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    busy = state == RUN;
    done = state == DONE;
    mag = dig.two ? mcand << 1 : dig.one ? mcand : '0;
    acc_nxt = dig.neg ? acc - mag : acc + mag;
  end
  // Multiplicand is extended to the full accumulator width so the
  // running sum wraps exactly; the multiplier gets a Booth guard bit below LSB.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mq <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      P <= '0;
`ifdef ALU_MUL_SEQ_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= '0;
        mcand <= {{(AW-WIDTH){is_signed & A[WIDTH-1]}}, A};
        mq <= {{2{is_signed & B[WIDTH-1]}}, B, 1'b0};
        cnt <= '0;
        sgn <= is_signed;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        mcand <= mcand << 2;
        mq <= mq >> 2;
        cnt <= cnt + 1'b1;
        if (last) begin
          P <= acc_nxt[2*WIDTH-1:0];
`ifdef ALU_MUL_SEQ_OVF_EN
          ovf <= sgn ? acc_nxt[2*WIDTH-1:WIDTH] != {WIDTH{acc_nxt[WIDTH-1]}}
                     : acc_nxt[2*WIDTH-1:WIDTH] != '0;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq (WIDTH=32) against a plain 64-bit arithmetic model
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic sg = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, done;
  logic [63:0] p;
  int errors = 0;
  int checks = 0;
`ifdef ALU_MUL_SEQ_OVF_EN
  logic ovf;
`endif

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .is_signed(sg),
    .A(op_a), .B(op_b), .busy(busy), .done(done),
`ifdef ALU_MUL_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .P(p)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ax, bx;
    ax = s ? {{32{a[31]}}, a} : {32'b0, a};
    bx = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

`ifdef ALU_MUL_SEQ_OVF_EN
  function automatic logic ovf_model(input logic [63:0] v, input logic s);
    return s ? v[63:32] != {32{v[31]}} : v[63:32] != 32'b0;
  endfunction
`endif

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] got, output int lat, output int bz);
    op_a = a; op_b = b; sg = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bz = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bz++;
    end
    if (!done) lat = -1;
    got = p;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 64'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b P=%h, required 0 0 0", busy, done, p);
    end
`ifdef ALU_MUL_SEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] vb [6] = '{32'hFFFFFFFD, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] ve [6] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'hFFFFFFFF_80000000,
                           64'hFFFFFFFE_00000001, 64'h00000000_00000001, 64'h0};
    logic [63:0] got;
    int lat, bz;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], got, lat, bz);
      checks++;
      if (got !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d: P=%h required %h", i, got, ve[i]);
      end
      checks++;
      if (lat != 17 || bz != 17) begin
        errors++;
        $display("FAIL latency_%0d: done after %0d busy %0d, required 17 17", i, lat, bz);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== ve[5]) begin
      errors++;
      $display("FAIL hold_idle: done=%b busy=%b P=%h required 0 0 %h", done, busy, p, ve[5]);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, b;
    logic s;
    logic [63:0] got, exp;
    int lat, bz;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      s = 1'($urandom_range(0, 1));
      exp = model(a, b, s);
      run_op(a, b, s, got, lat, bz);
      checks++;
      if (got !== exp || lat != 17) begin
        errors++;
        $display("FAIL random_%0d: %h*%h s=%b P=%h lat=%0d required %h lat=17", i, a, b, s, got, lat, exp);
      end
`ifdef ALU_MUL_SEQ_OVF_EN
      checks++;
      if (ovf !== ovf_model(exp, s)) begin
        errors++;
        $display("FAIL random_ovf_%0d: got %b required %b", i, ovf, ovf_model(exp, s));
      end
`endif
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_clr_abort();
    logic [63:0] got;
    int lat, bz, early;
    op_a = 32'h1234; op_b = 32'h5678; sg = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 64'h0) begin
      errors++;
      $display("FAIL clr_abort: busy=%b done=%b P=%h required 0 0 0", busy, done, p);
    end
    clr = 1'b0;
    op_a = 32'd12; op_b = 32'd12; sg = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    early = 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = p;
    checks++;
    if (got !== 64'd144 || lat != 17) begin
      errors++;
      $display("FAIL clr_restart: P=%h lat=%0d required %h lat=17", got, lat, 64'd144);
    end
    bz = early;
  endtask

  task automatic test_ignore_start();
    logic [63:0] got;
    int lat;
    op_a = 32'd1000; op_b = 32'hFFFFFFF6; sg = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        op_a = 32'hDEADBEEF; op_b = 32'h5; sg = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    got = p;
    checks++;
    if (got !== model(32'd1000, 32'hFFFFFFF6, 1'b1) || lat != 17) begin
      errors++;
      $display("FAIL ignore_start: P=%h lat=%0d required %h lat=17", got, lat, model(32'd1000, 32'hFFFFFFF6, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    int lat, bz;
    run_op(32'd99, 32'd101, 1'b0, got, lat, bz);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      run_op(a, b, 1'b1, got, lat, bz);
      checks++;
      if (got !== model(a, b, 1'b1) || lat != 17 || bz != 17) begin
        errors++;
        $display("FAIL back_to_back_%0d: P=%h lat=%0d busy=%0d required %h 17 17", i, got, lat, bz, model(a, b, 1'b1));
      end
    end
  endtask

`ifdef ALU_MUL_SEQ_OVF_EN
  task automatic test_ovf();
    logic [31:0] va [3] = '{32'h00010000, 32'd3, 32'hFFFFFFFF};
    logic [31:0] vb [3] = '{32'h00010000, 32'hFFFFFFFC, 32'd2};
    logic vs [3] = '{1'b1, 1'b1, 1'b0};
    logic ve [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] got;
    int lat, bz;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vs[i], got, lat, bz);
      checks++;
      if (ovf !== ve[i] || got !== model(va[i], vb[i], vs[i])) begin
        errors++;
        $display("FAIL ovf_%0d: ovf=%b P=%h required %b %h", i, ovf, got, ve[i], model(va[i], vb[i], vs[i]));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovf !== ve[2]) begin
      errors++;
      $display("FAIL ovf_hold: got %b required %b", ovf, ve[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_clr_abort();
    test_ignore_start();
    test_back_to_back();
`ifdef ALU_MUL_SEQ_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; even, >= 4.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: clr  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only when the block is idle or done.
REQ-005 SHALL have port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port: A  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port: B  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port: busy  output  1  high while iterating.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, product valid.
REQ-010 SHALL have port: P  output  2*WIDTH  product; {HI,LO} split at bit WIDTH.

Function
REQ-011 SHALL implement an iterative radix-4 Booth multiplier: one recoded digit in {-2,-1,0,+1,+2} retired per clock.
REQ-012 SHALL extend both operands to WIDTH+2 bits: sign-extend if is_signed, zero-extend otherwise.
REQ-013 SHALL use a fixed iteration count ITER = WIDTH/2+1 in both modes, so latency does not depend on the data.
REQ-014 SHALL use FSM states IDLE, RUN, DONE:
  - IDLE->RUN on start.
  - RUN->DONE when the iteration counter reaches ITER-1.
  - DONE->RUN on start, otherwise DONE->IDLE.
REQ-015 SHALL latch A, B and is_signed, clear the accumulator and counter, and enter RUN at the edge where start is accepted (E0).
REQ-016 SHALL perform one iteration per edge E0+1 .. E0+ITER; done=1 and P valid in the cycle after edge E0+ITER (17 iterations for WIDTH=32).
REQ-017 SHALL hold busy=1 exactly in RUN and done=1 exactly in DONE.
REQ-018 SHALL ignore start while busy=1; latched operands are unaffected by input changes during RUN.
REQ-019 SHALL accept start in the DONE cycle (back-to-back), with no idle bubble.
REQ-020 SHALL hold P at the last completed product until the next accepted start.
REQ-021 SHALL accumulate in at least 2*WIDTH+2 bits; P is the low 2*WIDTH bits, exact modulo 2^(2*WIDTH) in both modes.
REQ-022 SHALL give a -2*A digit the same result as negation of 2*A; the most negative A (e.g. 0x80000000) SHALL produce the exact result.

Reset
REQ-023 SHALL, when clr=1 at an edge, drive state IDLE, busy=0, done=0, P=0, counter=0 and internal registers=0, regardless of state.
REQ-024 SHALL give clr priority over start; a clr during RUN aborts the operation with no done pulse.
REQ-025 SHALL accept start in the first cycle after clr is released.

Configuration
REQ-026 SHALL, with macro ALU_MUL_SEQ_OVF_EN defined, add port "ovf  output  1" with this behaviour:
  - valid with done and held alongside P.
  - signed mode: ovf=1 when P[2*WIDTH-1:WIDTH] is not the sign-extension of P[WIDTH-1].
  - unsigned mode: ovf=1 when P[2*WIDTH-1:WIDTH] is nonzero.
  - reset value 0.
REQ-027 SHALL, without ALU_MUL_SEQ_OVF_EN, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place in shared package alu_mul_pkg:
  - the FSM state enum.
  - the Booth digit typedef (neg, one, two fields).
  - the ITER computation function.
REQ-029 SHALL use one sub-module, booth_r4_enc: 3 multiplier bits -> Booth digit, purely combinational.

Verification
REQ-030 SHALL cover (WIDTH=32): signed 7 * -3 -> P=0xFFFFFFFF_FFFFFFEB, done exactly 17 cycles after the start edge, busy high for 17 cycles.
REQ-031 SHALL cover: signed 0x80000000 * 0x80000000 -> P=0x40000000_00000000; signed 0x80000000 * 1 -> P=0xFFFFFFFF_80000000.
REQ-032 SHALL cover: 0xFFFFFFFF * 0xFFFFFFFF -> unsigned P=0xFFFFFFFE_00000001; signed P=0x00000000_00000001.
REQ-033 SHALL cover: clr at iteration 5 -> next cycle busy=0, done=0, P=0; then 12 * 12 -> P=144, no stale done.
REQ-034 SHALL cover: start during RUN with new operands -> ignored, original product returned; start in the DONE cycle -> next product done 17 cycles later.
REQ-035 SHALL cover, with ALU_MUL_SEQ_OVF_EN: signed 0x00010000 * 0x00010000 -> ovf=1; signed 3 * -4 -> ovf=0; unsigned 0xFFFFFFFF * 2 -> ovf=1.
